// File: rtl/present80_iter_ctrl.sv
// Iterative PRESENT-80 encryption core.
// One shared round datapath (addRoundKey, sLayer, pLayer) and an on-the-fly
// key schedule, sequenced by an IDLE/RUN/DONE FSM at one round per clock.
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid
// is high only in DONE, and out_ct is held stable until the transfer. A
// source must keep its data steady while valid is high and ready is low.
module present80_iter_ctrl #(
  parameter int ROUNDS = 31,
  parameter int RC_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pt,
  input  logic [79:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_ct,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            fsm_q;
  logic [63:0]       data_q;
  logic [79:0]       key_q;
  logic [RC_W-1:0]   rc_q;
  logic [63:0]       out_ct_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;

  logic [63:0]       round_d;
  logic [79:0]       key_d;
  logic [4:0]        rc5;

  // 4-bit PRESENT S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  // S-box applied to all 16 nibbles independently.
  function automatic logic [63:0] s_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i goes to bit (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(16 * i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Key register update: rotate left 61, S-box the top nibble, mix in rc.
  function automatic logic [79:0] key_update(input logic [79:0] k,
                                             input logic [4:0]  rc);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  assign rc5 = 5'(rc_q);

  // Round datapath: current round key is the top 64 bits of the key register.
  always_comb begin
    round_d = p_layer(s_layer(data_q ^ key_q[79:16]));
    key_d   = key_update(key_q, rc5);
  end

  // Control FSM with registered outputs; datapath registers load alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      data_q      <= '0;
      key_q       <= '0;
      rc_q        <= '0;
      out_ct_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_pt;
            key_q      <= in_key;
            rc_q       <= RC_W'(1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          data_q <= round_d;
          key_q  <= key_d;
          rc_q   <= rc_q + RC_W'(1);
          if (rc_q == RC_W'(ROUNDS)) begin
            // Last round: fold in the final whitening key K32.
            out_ct_q    <= round_d ^ key_d[79:16];
            out_valid_q <= 1'b1;
            fsm_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            fsm_q       <= ST_IDLE;
          end
        end
        default: begin
          fsm_q       <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ct    = out_ct_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_present80_iter_ctrl.sv
// Directed bench for present80_iter_ctrl using published PRESENT-80 vectors.
module tb_present80_iter_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pt;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_ct;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] PT0  = 64'h0000000000000000;
  localparam logic [63:0] PT1  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [79:0] K0   = 80'h00000000000000000000;
  localparam logic [79:0] K1   = 80'hFFFFFFFFFFFFFFFFFFFF;
  localparam logic [63:0] CT00 = 64'h5579C1387B228445;
  localparam logic [63:0] CT01 = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT10 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT11 = 64'h3333DCD3213210D2;

  present80_iter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one block and take it on the next edge; leaves in_valid low.
  task automatic accept(input logic [63:0] pt, input logic [79:0] key);
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    chk("pre_accept_in_ready", 80'(in_ready), 80'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("post_accept_busy", 80'(busy), 80'd1);
    chk("post_accept_in_ready", 80'(in_ready), 80'd0);
  endtask

  // Count edges until out_valid; flags any in_ready seen while waiting.
  task automatic wait_out(output int cyc, output int rdy_bad,
                          input bit scramble);
    cyc     = 0;
    rdy_bad = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (in_ready !== 1'b0) rdy_bad++;
      if (scramble && out_valid !== 1'b1) begin
        in_pt     = {$urandom, $urandom};
        in_key    = {16'($urandom), $urandom, $urandom};
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    if (scramble) begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
    end
  endtask

  // Single output handshake and return to IDLE.
  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_out_valid"}, 80'(out_valid), 80'd0);
    chk({tag, "_hs_in_ready"}, 80'(in_ready), 80'd1);
    chk({tag, "_hs_busy"}, 80'(busy), 80'd0);
  endtask

  int cyc;
  int rdy_bad;
  int bad;

  // Directed test sequence.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_out_ct", 80'(out_ct), 80'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Vector 0: all-zero plaintext and key, with latency check.
    accept(PT0, K0);
    wait_out(cyc, rdy_bad, 1'b0);
    chk("v0_latency", 80'(cyc), 80'd31);
    chk("v0_ready_low_run", 80'(rdy_bad), 80'd0);
    chk("v0_ct", 80'(out_ct), 80'(CT00));
    chk("v0_busy_done", 80'(busy), 80'd1);
    handshake("v0");

    // Vector 3 with a 20-cycle consumer stall.
    accept(PT1, K1);
    wait_out(cyc, rdy_bad, 1'b0);
    chk("v3_latency", 80'(cyc), 80'd31);
    chk("v3_ct", 80'(out_ct), 80'(CT11));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_ct !== CT11 || in_ready !== 1'b0) bad++;
    end
    chk("v3_hold_stable", 80'(bad), 80'd0);
    handshake("v3");
    chk("v3_ct_after_hs", 80'(out_ct), 80'(CT11));

    // Back-to-back: in_valid and out_ready held high, vectors 1 then 2.
    out_ready = 1'b1;
    in_pt     = PT0;
    in_key    = K1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_first_accept", 80'(busy), 80'd1);
    in_pt  = PT1;
    in_key = K0;
    wait_out(cyc, rdy_bad, 1'b0);
    chk("b2b_v1_latency", 80'(cyc), 80'd31);
    chk("b2b_v1_ready_low", 80'(rdy_bad), 80'd0);
    chk("b2b_v1_ct", 80'(out_ct), 80'(CT01));
    @(posedge clk);
    #1;
    chk("b2b_hs_out_valid", 80'(out_valid), 80'd0);
    chk("b2b_hs_in_ready", 80'(in_ready), 80'd1);
    @(posedge clk);
    #1;
    chk("b2b_second_accept", 80'(busy), 80'd1);
    chk("b2b_second_in_ready", 80'(in_ready), 80'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_out(cyc, rdy_bad, 1'b0);
    chk("b2b_v2_latency", 80'(cyc), 80'd31);
    chk("b2b_v2_ready_low", 80'(rdy_bad), 80'd0);
    chk("b2b_v2_ct", 80'(out_ct), 80'(CT10));
    handshake("b2b");

    // Reset during RUN cycle 10, then vector 1 from scratch.
    accept(PT1, K1);
    repeat (9) @(posedge clk);
    #1;
    chk("mid_run_busy", 80'(busy), 80'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 80'(in_ready), 80'd1);
    chk("mid_rst_out_valid", 80'(out_valid), 80'd0);
    chk("mid_rst_busy", 80'(busy), 80'd0);
    chk("mid_rst_out_ct", 80'(out_ct), 80'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mid_rst_no_spurious", 80'(bad), 80'd0);
    accept(PT0, K1);
    wait_out(cyc, rdy_bad, 1'b0);
    chk("post_rst_latency", 80'(cyc), 80'd31);
    chk("post_rst_ct", 80'(out_ct), 80'(CT01));
    handshake("post_rst");

    // Inputs scrambled while busy must not disturb the captured block.
    accept(PT1, K0);
    wait_out(cyc, rdy_bad, 1'b1);
    chk("scr_latency", 80'(cyc), 80'd31);
    chk("scr_ready_low", 80'(rdy_bad), 80'd0);
    chk("scr_ct", 80'(out_ct), 80'(CT10));
    handshake("scr");
    repeat (3) @(posedge clk);
    #1;
    chk("scr_idle_busy", 80'(busy), 80'd0);
    chk("scr_idle_out_valid", 80'(out_valid), 80'd0);

    // Reset while holding a result in DONE.
    accept(PT0, K0);
    wait_out(cyc, rdy_bad, 1'b0);
    chk("done_rst_pre_valid", 80'(out_valid), 80'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("done_rst_out_valid", 80'(out_valid), 80'd0);
    chk("done_rst_out_ct", 80'(out_ct), 80'd0);
    chk("done_rst_in_ready", 80'(in_ready), 80'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
